// File: rtl/ascon_tag_verify.sv
// ascon_tag_verify: recomputes the ASCON tag via iterative p12 and checks it against the received tag.
// Latency: accept at cycle N -> out_valid at cycle N + 12/UNROLL + 1.
// Backpressure: out_ready low holds DONE (and the verdict) indefinitely; no new bundle is taken until release.
// Optional debug build: define ASCON_TAG_VERIFY_DEBUG_EN to expose tag_calc and round_cnt.
module ascon_tag_verify #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [63:0]  x0_i,
   input  logic [63:0]  x1_i,
   input  logic [63:0]  x2_i,
   input  logic [63:0]  x3_i,
   input  logic [63:0]  x4_i,
   input  logic [127:0] tag_rx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         tag_ok
`ifdef ASCON_TAG_VERIFY_DEBUG_EN
   ,
   output logic [127:0] tag_calc,
   output logic [3:0]   round_cnt
`endif
);

   // Only divisors of 12 let the round counter land exactly on 12.
   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 ||
         UNROLL == 4 || UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
      $error("ascon_tag_verify: UNROLL must be one of 1,2,3,4,6,12");
   end

   typedef struct packed {
      logic [63:0] x0;
      logic [63:0] x1;
      logic [63:0] x2;
      logic [63:0] x3;
      logic [63:0] x4;
   } ascon_st_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PERM = 2'd1,
      DONE = 2'd2
   } fsm_e;

   // One ASCON round: constant add, bitsliced S-box, linear diffusion.
   function automatic ascon_st_t ascon_round(input ascon_st_t s, input logic [3:0] r);
      ascon_st_t a;
      logic [63:0] t0, t1, t2, t3, t4;
      a = s;
      a.x2 = a.x2 ^ {56'd0, (4'hF - r), r};
      a.x0 = a.x0 ^ a.x4;
      a.x4 = a.x4 ^ a.x3;
      a.x2 = a.x2 ^ a.x1;
      t0 = ~a.x0 & a.x1;
      t1 = ~a.x1 & a.x2;
      t2 = ~a.x2 & a.x3;
      t3 = ~a.x3 & a.x4;
      t4 = ~a.x4 & a.x0;
      a.x0 = a.x0 ^ t1;
      a.x1 = a.x1 ^ t2;
      a.x2 = a.x2 ^ t3;
      a.x3 = a.x3 ^ t4;
      a.x4 = a.x4 ^ t0;
      a.x1 = a.x1 ^ a.x0;
      a.x0 = a.x0 ^ a.x4;
      a.x3 = a.x3 ^ a.x2;
      a.x2 = ~a.x2;
      ascon_round.x0 = a.x0 ^ {a.x0[18:0], a.x0[63:19]} ^ {a.x0[27:0], a.x0[63:28]};
      ascon_round.x1 = a.x1 ^ {a.x1[60:0], a.x1[63:61]} ^ {a.x1[38:0], a.x1[63:39]};
      ascon_round.x2 = a.x2 ^ {a.x2[0],    a.x2[63:1]}  ^ {a.x2[5:0],  a.x2[63:6]};
      ascon_round.x3 = a.x3 ^ {a.x3[9:0],  a.x3[63:10]} ^ {a.x3[16:0], a.x3[63:17]};
      ascon_round.x4 = a.x4 ^ {a.x4[6:0],  a.x4[63:7]}  ^ {a.x4[40:0], a.x4[63:41]};
   endfunction

   fsm_e         state_q, state_d;
   logic [3:0]   rc_q, rc_d;
   ascon_st_t    st_q, st_d;
   logic [127:0] key_q, key_d;
   logic [127:0] tag_q, tag_d;
   logic         tag_ok_q, tag_ok_d;

   ascon_st_t    perm_st;
   logic [127:0] calc_nxt;
   logic         last_step;

   // UNROLL chained rounds starting at the current round counter.
   always_comb begin
      perm_st = st_q;
      for (int k = 0; k < UNROLL; k++) begin
         perm_st = ascon_round(perm_st, rc_q + 4'(k));
      end
      calc_nxt  = {perm_st.x4 ^ key_q[63:0], perm_st.x3 ^ key_q[127:64]};
      last_step = ((rc_q + 4'(UNROLL)) == 4'd12);
   end

   // Next-state and datapath update for the IDLE/PERM/DONE controller.
   always_comb begin
      state_d  = state_q;
      rc_d     = rc_q;
      st_d     = st_q;
      key_d    = key_q;
      tag_d    = tag_q;
      tag_ok_d = tag_ok_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               key_d   = key;
               tag_d   = tag_rx;
               st_d.x0 = x0_i;
               st_d.x1 = x1_i;
               st_d.x2 = x2_i ^ key[127:64];
               st_d.x3 = x3_i ^ key[63:0];
               st_d.x4 = x4_i;
               rc_d    = 4'd0;
               state_d = PERM;
            end
         end
         PERM: begin
            st_d = perm_st;
            rc_d = rc_q + 4'(UNROLL);
            if (last_step) begin
               // Full-width XOR then OR-reduce: no data-dependent early exit.
               tag_ok_d = ~|(calc_nxt ^ tag_q);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               tag_ok_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            tag_ok_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rc_q     <= 4'd0;
         st_q     <= '0;
         key_q    <= '0;
         tag_q    <= '0;
         tag_ok_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rc_q     <= rc_d;
         st_q     <= st_d;
         key_q    <= key_d;
         tag_q    <= tag_d;
         tag_ok_q <= tag_ok_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign tag_ok    = tag_ok_q;

`ifdef ASCON_TAG_VERIFY_DEBUG_EN
   // Recomputed tag is only visible while the verdict is being presented.
   always_comb begin
      tag_calc = '0;
      if (state_q == DONE) begin
         tag_calc = {st_q.x4 ^ key_q[63:0], st_q.x3 ^ key_q[127:64]};
      end
   end
   assign round_cnt = rc_q;
`endif

endmodule

// File: tb/tb_ascon_tag_verify.sv
// Bench for ascon_tag_verify: three instances (UNROLL 1, 3, 12) share one stimulus stream.
// A table-driven ASCON model supplies the verdict; a per-cycle phase model supplies timing.
// Directed cases (match, bit flips, zero vector, backpressure, reset) precede a random run.
module tb_ascon_tag_verify;

   typedef logic [63:0] w64;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [127:0] key;
   logic [63:0]  x0_i, x1_i, x2_i, x3_i, x4_i;
   logic [127:0] tag_rx;
   logic         out_ready;
   logic [2:0]   ir, ov, ok;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 0;
   int perm_cyc[3] = '{12, 4, 1};

   ascon_tag_verify #(.UNROLL(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .key(key),
      .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
      .tag_rx(tag_rx), .out_valid(ov[0]), .out_ready(out_ready), .tag_ok(ok[0]));

   ascon_tag_verify #(.UNROLL(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .key(key),
      .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
      .tag_rx(tag_rx), .out_valid(ov[1]), .out_ready(out_ready), .tag_ok(ok[1]));

   ascon_tag_verify #(.UNROLL(12)) u_dut12 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .key(key),
      .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
      .tag_rx(tag_rx), .out_valid(ov[2]), .out_ready(out_ready), .tag_ok(ok[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic logic [4:0] sbox5(input logic [4:0] v);
      case (v)
         5'h00: sbox5 = 5'h04; 5'h01: sbox5 = 5'h0b; 5'h02: sbox5 = 5'h1f; 5'h03: sbox5 = 5'h14;
         5'h04: sbox5 = 5'h1a; 5'h05: sbox5 = 5'h15; 5'h06: sbox5 = 5'h09; 5'h07: sbox5 = 5'h02;
         5'h08: sbox5 = 5'h1b; 5'h09: sbox5 = 5'h05; 5'h0a: sbox5 = 5'h08; 5'h0b: sbox5 = 5'h12;
         5'h0c: sbox5 = 5'h1d; 5'h0d: sbox5 = 5'h03; 5'h0e: sbox5 = 5'h06; 5'h0f: sbox5 = 5'h1c;
         5'h10: sbox5 = 5'h1e; 5'h11: sbox5 = 5'h13; 5'h12: sbox5 = 5'h07; 5'h13: sbox5 = 5'h0e;
         5'h14: sbox5 = 5'h00; 5'h15: sbox5 = 5'h0d; 5'h16: sbox5 = 5'h11; 5'h17: sbox5 = 5'h18;
         5'h18: sbox5 = 5'h10; 5'h19: sbox5 = 5'h0c; 5'h1a: sbox5 = 5'h01; 5'h1b: sbox5 = 5'h19;
         5'h1c: sbox5 = 5'h16; 5'h1d: sbox5 = 5'h0a; 5'h1e: sbox5 = 5'h0f; default: sbox5 = 5'h17;
      endcase
   endfunction

   function automatic w64 ror(input w64 v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Column-wise table lookup S-box; word 0 is the MSB of each column.
   function automatic logic [319:0] model_round(input logic [319:0] st, input int r);
      w64 s[5];
      w64 o[5];
      logic [4:0] col;
      for (int i = 0; i < 5; i++) s[i] = st[319 - 64*i -: 64];
      s[2] = s[2] ^ 64'(((15 - r) * 16) + r);
      for (int b = 0; b < 64; b++) begin
         col = sbox5({s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]});
         for (int i = 0; i < 5; i++) o[i][b] = col[4 - i];
      end
      o[0] = o[0] ^ ror(o[0], 19) ^ ror(o[0], 28);
      o[1] = o[1] ^ ror(o[1], 61) ^ ror(o[1], 39);
      o[2] = o[2] ^ ror(o[2], 1)  ^ ror(o[2], 6);
      o[3] = o[3] ^ ror(o[3], 10) ^ ror(o[3], 17);
      o[4] = o[4] ^ ror(o[4], 7)  ^ ror(o[4], 41);
      return {o[0], o[1], o[2], o[3], o[4]};
   endfunction

   function automatic logic [127:0] model_tag(input logic [127:0] k, input w64 a0, input w64 a1,
                                              input w64 a2, input w64 a3, input w64 a4);
      logic [319:0] st;
      st = {a0, a1, a2 ^ k[127:64], a3 ^ k[63:0], a4};
      for (int r = 0; r < 12; r++) st = model_round(st, r);
      return {st[63:0] ^ k[63:0], st[127:64] ^ k[127:64]};
   endfunction

   // ---------------- check helpers ----------------
   task automatic chk_bit(input string nm, input int d, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d @%0t: got %b expected %b", nm, d, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int d, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, d, $time, act, exp);
      end
   endtask

   task automatic chk_w64(input string nm, input w64 act, input w64 exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- per-cycle compare against phase model ----------------
   int   ph[3];
   int   rem[3];
   logic vd[3];

   initial begin
      logic v_now;
      for (int d = 0; d < 3; d++) begin ph[d] = 0; rem[d] = 0; vd[d] = 1'b0; end
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
               chk_bit("cyc_in_ready", d, ir[d], ph[d] == 0);
               chk_bit("cyc_out_valid", d, ov[d], ph[d] == 2);
               chk_bit("cyc_tag_ok", d, ok[d], (ph[d] == 2) ? vd[d] : 1'b0);
            end
            v_now = 1'b0;
            if (in_valid) v_now = (model_tag(key, x0_i, x1_i, x2_i, x3_i, x4_i) == tag_rx);
            for (int d = 0; d < 3; d++) begin
               if (rst) begin
                  ph[d] = 0; vd[d] = 1'b0;
               end else if (ph[d] == 0) begin
                  if (in_valid) begin ph[d] = 1; rem[d] = perm_cyc[d]; vd[d] = v_now; end
               end else if (ph[d] == 1) begin
                  rem[d]--;
                  if (rem[d] == 0) ph[d] = 2;
               end else if (out_ready) begin
                  ph[d] = 0; vd[d] = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic scramble();
      key    = {$urandom, $urandom, $urandom, $urandom};
      x0_i   = {$urandom, $urandom};
      x1_i   = {$urandom, $urandom};
      x2_i   = {$urandom, $urandom};
      x3_i   = {$urandom, $urandom};
      x4_i   = {$urandom, $urandom};
      tag_rx = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (ir != 3'b111 && n < 50) begin tick(); n++; end
      if (ir != 3'b111) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_idle: in_ready=%b after %0d cycles, required 111", ir, n);
      end
   endtask

   task automatic accept(input logic [127:0] k, input w64 a0, input w64 a1, input w64 a2,
                         input w64 a3, input w64 a4, input logic [127:0] t);
      wait_idle();
      key = k; x0_i = a0; x1_i = a1; x2_i = a2; x3_i = a3; x4_i = a4; tag_rx = t;
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      scramble();
   endtask

   task automatic run_vec(input logic [127:0] k, input w64 a0, input w64 a1, input w64 a2,
                          input w64 a3, input w64 a4, input logic [127:0] t,
                          input logic exp_ok, input int hold);
      int cyc;
      logic [2:0] seen;
      int lat[3];
      logic okv[3];
      accept(k, a0, a1, a2, a3, a4, t);
      seen = 3'b000; cyc = 1;
      for (int d = 0; d < 3; d++) begin lat[d] = -1; okv[d] = 1'bx; end
      while (seen != 3'b111 && cyc < 40) begin
         for (int d = 0; d < 3; d++) begin
            if (!seen[d] && ov[d]) begin seen[d] = 1'b1; lat[d] = cyc; okv[d] = ok[d]; end
         end
         // Busy blocks must ignore offered bundles.
         in_valid = $urandom_range(0, 1);
         tick(); cyc++;
      end
      for (int d = 0; d < 3; d++) begin
         chk_int("latency", d, lat[d], perm_cyc[d] + 1);
         chk_bit("verdict", d, okv[d], exp_ok);
      end
      for (int h = 0; h < hold; h++) begin
         in_valid = $urandom_range(0, 1);
         scramble();
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk_bit("release_in_ready", d, ir[d], 1'b1);
         chk_bit("release_out_valid", d, ov[d], 1'b0);
      end
   endtask

   initial begin
      logic [127:0] gk, gt, t, flip;
      w64 g0, g1, g2, g3, g4;
      logic [319:0] r1;
      int sel;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      scramble();
      tick();
      mon_en = 1'b1;
      for (int d = 0; d < 3; d++) begin
         chk_bit("reset_in_ready", d, ir[d], 1'b1);
         chk_bit("reset_out_valid", d, ov[d], 1'b0);
         chk_bit("reset_tag_ok", d, ok[d], 1'b0);
      end
      tick();
      rst = 1'b0;

      // One round on the all-zero state, worked by hand.
      r1 = model_round(320'd0, 0);
      chk_w64("model_round0_x0", r1[319:256], 64'h001E0F00000000F0);
      chk_w64("model_round0_x1", r1[255:192], 64'h00000001E0000770);
      chk_w64("model_round0_x4", r1[63:0], 64'h0);

      gk = 128'h000102030405060708090A0B0C0D0E0F;
      g0 = 64'h80400C0600000000; g1 = 64'h0011223344556677; g2 = 64'h8899AABBCCDDEEFF;
      g3 = 64'h0F1E2D3C4B5A6978; g4 = 64'hDEADBEEFCAFEF00D;
      gt = model_tag(gk, g0, g1, g2, g3, g4);

      run_vec(gk, g0, g1, g2, g3, g4, gt, 1'b1, 0);
      flip = 128'd1;
      run_vec(gk, g0, g1, g2, g3, g4, gt ^ flip, 1'b0, 0);
      flip = 128'd1 << 127;
      run_vec(gk, g0, g1, g2, g3, g4, gt ^ flip, 1'b0, 0);
      t = model_tag(128'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
      run_vec(128'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 128'd0, (t == 128'd0), 0);
      run_vec(128'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, t, 1'b1, 0);
      // Backpressure: hold the result for 20 cycles.
      run_vec(gk, g0, g1, g2, g3, g4, gt, 1'b1, 20);

      // Reset in the middle of the permutation.
      accept(gk, g0, g1, g2, g3, g4, gt);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk_bit("midrst_in_ready", d, ir[d], 1'b1);
         chk_bit("midrst_out_valid", d, ov[d], 1'b0);
         chk_bit("midrst_tag_ok", d, ok[d], 1'b0);
      end
      run_vec(gk, g0, g1, g2, g3, g4, gt, 1'b1, 3);

      // Random traffic: shared stream, each instance tracked independently.
      for (int i = 0; i < 3000; i++) begin
         scramble();
         in_valid  = ($urandom % 10) < 3;
         out_ready = ($urandom % 10) < 7;
         rst       = ($urandom % 250) == 0;
         if (in_valid) begin
            sel = $urandom % 4;
            t = model_tag(key, x0_i, x1_i, x2_i, x3_i, x4_i);
            flip = 128'd1 << ($urandom % 128);
            if (sel == 1) tag_rx = t ^ flip;
            else if (sel != 2) tag_rx = t;
         end
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) tick();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ascon_tag_verify.md
Name: ascon_tag_verify

Overview:
- Decryption-side counterpart of the encryption finalization stage.
- Takes the post-ciphertext ASCON state, the key and the received tag.
- Runs the finalization permutation p12 iteratively over multiple cycles and recomputes the tag with the same key-XOR mapping the encryptor uses.
- Compares the recomputed tag against the received tag in constant time, then reports pass/fail over a valid/ready handshake to the decryption controller.

Parameters:
- UNROLL, 1, rounds evaluated per clock. Legal values are 1, 2, 3, 4, 6, 12. Any other value is a elaboration error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept a bundle.
- key  in  128  cipher key.
- x0_i..x4_i  in  64 each  state after the last ciphertext block, before the key XOR.
- tag_rx  in  128  received tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- tag_ok  out  1  1 = tags match; qualified by out_valid.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, tag_ok=0, round counter=0, state=IDLE. State, key and tag registers are cleared to 0.
- FSM states: IDLE, PERM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register key and tag_rx.
  - Load s0=x0_i, s1=x1_i, s2=x2_i^key[127:64], s3=x3_i^key[63:0], s4=x4_i.
  - Set rc=0 and go to PERM.
- PERM:
  - in_ready=0.
  - Each cycle applies UNROLL consecutive rounds r=rc..rc+UNROLL-1, then rc+=UNROLL.
  - Round r:
    - Constant add: s2 ^= ((4'hF-r)<<4)|r, using 8 bits zero-extended.
    - Standard ASCON 5-bit S-box, bitsliced.
    - Linear layer rotations (right): s0 by 19,28; s1 by 61,39; s2 by 1,6; s3 by 10,17; s4 by 7,41.
  - When rc+UNROLL==12, the final rounds are applied and the FSM goes to DONE.
- Entering DONE:
  - Recompute the tag as calc[127:64]=s4^key[63:0], calc[63:0]=s3^key[127:64]. This mapping is bit-exact with the encrypt-side finalization.
  - tag_ok is registered as ~|(calc^tag_rx): full 128-bit XOR then OR-reduce, with no early exit.
- DONE:
  - out_valid=1 and tag_ok stays stable until out_valid&out_ready.
  - On that handshake, out_valid=0, tag_ok=0 and the FSM returns to IDLE.
- Latency: handshake at cycle N gives out_valid at cycle N+12/UNROLL+1 (13 cycles for UNROLL=1, 2 cycles for UNROLL=12).
- Accept/release overlap: there is no overlap. A new bundle is accepted only in IDLE, so the earliest accept is the cycle after the output handshake.
- Backpressure: out_ready low holds DONE indefinitely. No state or result changes while held.
- Input stability: in_valid while not in IDLE is ignored. Inputs need only be stable during the handshake cycle.
- Reset mid-operation: rst in any state forces the reset values on the next edge. The pending result is discarded, out_valid never pulses, and register contents are zeroed.
- Timing independence: the verdict and its timing are independent of tag_rx contents.

Optional Feature:
- Macro: ASCON_TAG_VERIFY_DEBUG_EN.
- When defined:
  - Adds output port tag_calc (128 bits), driven with calc while out_valid=1 and 0 otherwise.
  - Adds output round_cnt (4 bits) mirroring rc.
- When undefined: neither port exists, and the recomputed tag never leaves the block. Production builds leave the macro undefined.

Test Plan:
- Known-good match: state and key from the encrypt-side golden model; tag_rx = model tag. Handshake at cycle 0 gives out_valid=1 and tag_ok=1 at cycle 13 with UNROLL=1.
- Single-bit mismatch: same vectors with tag_rx bit 0 flipped, then bit 127 flipped (separate runs). Each gives tag_ok=0 at cycle 13, with identical timing to the match case.
- All-zero vector: key=0, x0..x4=0, tag_rx=0. Result equals the model's tag_ok with latency 13. In the debug build, tag_calc equals the model p12 output (x4||x3).
- Backpressure: out_ready=0 for 20 cycles after out_valid. out_valid and tag_ok stay stable and in_ready=0 throughout. out_ready=1 gives out_valid=0 next cycle and in_ready=1.
- Reset mid-PERM: assert rst at cycle 5 after accept. Next cycle in_ready=1 and out_valid=0; a fresh bundle then completes normally with the correct verdict.
- UNROLL sweep: UNROLL=1,3,12 on identical vectors gives identical tag_ok, with latencies 13, 5 and 2 cycles respectively.
